// File: rtl/ace_ccu_snoop_resp_pipe.sv
// ace_ccu_snoop_resp_pipe: multi-outstanding snoop response combiner.
// Queues snoop masks and merges each transaction's CR responses in order.
// It then forwards one responder's CD burst and drains all other CD bursts.
// Optional feature macro: ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
//   (prefer PassDirty responders).
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   oup_sel_*               mask of masters snooped by a new transaction
//   cr_valids_i/readies_o   per-master CR, cr_chans_i packed 5 bits/master
//                           {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   cd_valids_i/readies_o   per-master CD, cd_chans_i packed CdW bits/master,
//                           bit 0 = last
//   cr_*_o / cr_ready_i     merged CR towards the CCU
//   cd_*_o / cd_ready_i     forwarded CD towards the CCU
//   trans_cnt_o             transactions accepted and not yet retired

module ace_ccu_snoop_resp_pipe_fifo #(
    parameter int W     = 1,
    parameter int Depth = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [W-1:0]  r_mem [Depth];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == CW'(Depth));
    assign data_o  = r_mem[r_rp];

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wp] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wp <= ptr_inc(r_wp);
            if (pop_i)  r_rp <= ptr_inc(r_rp);
            if (push_i && !pop_i)      r_cnt <= r_cnt + 1'b1;
            else if (!push_i && pop_i) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

module ace_ccu_snoop_resp_pipe #(
    parameter int NumOup   = 2,
    parameter int MaxTrans = 4,
    parameter int CdW      = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumOup-1:0]           oup_sel_i,
    input  logic                        oup_sel_valid_i,
    output logic                        oup_sel_ready_o,
    input  logic [NumOup-1:0]           cr_valids_i,
    output logic [NumOup-1:0]           cr_readies_o,
    input  logic [NumOup*5-1:0]         cr_chans_i,
    input  logic [NumOup-1:0]           cd_valids_i,
    output logic [NumOup-1:0]           cd_readies_o,
    input  logic [NumOup*CdW-1:0]       cd_chans_i,
    output logic                        cr_valid_o,
    input  logic                        cr_ready_i,
    output logic [4:0]                  cr_chan_o,
    output logic                        cd_valid_o,
    input  logic                        cd_ready_i,
    output logic [CdW-1:0]              cd_chan_o,
    output logic [$clog2(MaxTrans+1)-1:0] trans_cnt_o
);
    localparam int CrW  = 5;
    localparam int FW   = (NumOup > 1) ? $clog2(NumOup) : 1;
    localparam int CntW = $clog2(MaxTrans + 1);
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
    localparam int QW = 2 * NumOup;
`else
    localparam int QW = NumOup;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_STREAM
    } state_e;

    // Sel queue
    logic              w_sq_push;
    logic              w_sq_pop;
    logic [NumOup-1:0] w_sq_head;
    logic              w_sq_empty;
    logic              w_sq_full;

    // CD queue
    logic              w_cq_push;
    logic              w_cq_pop;
    logic [QW-1:0]     w_cq_in;
    logic [QW-1:0]     w_cq_head;
    logic              w_cq_empty;
    logic              w_cq_full;
    logic [NumOup-1:0] w_cq_d;

    // CR merge
    logic [NumOup-1:0] w_m;
    logic              w_all_vld;
    logic [CrW-1:0]    w_cr_or;
    logic [NumOup-1:0] w_dt;
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
    logic [NumOup-1:0] w_pd;
    logic [NumOup-1:0] w_cq_p;
`endif

    // CD FSM
    state_e            r_state;
    state_e            w_state_nxt;
    logic [FW-1:0]     r_first;
    logic [NumOup-1:0] r_done;
    logic [NumOup-1:0] w_cand;
    logic [FW-1:0]     w_pick;
    logic              w_pick_vld;
    logic              w_busy;
    logic              w_fwd;
    logic [FW-1:0]     w_fsel;
    logic [NumOup-1:0] w_last_hs;
    logic [NumOup-1:0] w_done_nxt;
    logic              w_all_done;

    logic [CntW-1:0]   r_cnt;

    ace_ccu_snoop_resp_pipe_fifo #(
        .W     (NumOup),
        .Depth (MaxTrans)
    ) u_sq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_sq_push),
        .data_i  (oup_sel_i),
        .pop_i   (w_sq_pop),
        .data_o  (w_sq_head),
        .empty_o (w_sq_empty),
        .full_o  (w_sq_full)
    );

    ace_ccu_snoop_resp_pipe_fifo #(
        .W     (QW),
        .Depth (MaxTrans)
    ) u_cq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_cq_push),
        .data_i  (w_cq_in),
        .pop_i   (w_cq_pop),
        .data_o  (w_cq_head),
        .empty_o (w_cq_empty),
        .full_o  (w_cq_full)
    );

    assign oup_sel_ready_o = !w_sq_full;
    assign w_sq_push       = oup_sel_valid_i && !w_sq_full;

    // An empty SQ is treated as a zero mask so no CR ready leaks out.
    assign w_m = w_sq_empty ? '0 : w_sq_head;

    always_comb begin
        w_all_vld = 1'b1;
        w_cr_or   = '0;
        w_dt      = '0;
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
        w_pd      = '0;
`endif
        for (int j = 0; j < NumOup; j++) begin
            w_all_vld = w_all_vld & (cr_valids_i[j] | ~w_m[j]);
            w_cr_or   = w_cr_or |
                        ({CrW{w_m[j]}} & cr_chans_i[j*CrW +: CrW]);
            w_dt[j]   = w_m[j] & cr_chans_i[j*CrW];
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
            w_pd[j]   = w_m[j] & cr_chans_i[j*CrW + 2];
`endif
        end
    end

    assign cr_valid_o   = !w_sq_empty && !w_cq_full && w_all_vld;
    assign cr_chan_o    = w_cr_or;
    assign cr_readies_o = w_m & {NumOup{cr_valid_o & cr_ready_i}};
    assign w_sq_pop     = cr_valid_o && cr_ready_i;
    assign w_cq_push    = w_sq_pop;

`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
    assign w_cq_in = {w_pd, w_dt};
    assign w_cq_d  = w_cq_head[NumOup-1:0];
    assign w_cq_p  = w_cq_head[2*NumOup-1:NumOup];
`else
    assign w_cq_in = w_dt;
    assign w_cq_d  = w_cq_head;
`endif

    // First-responder candidates; dirty holders win when present.
    always_comb begin
        w_cand = w_cq_d & cd_valids_i;
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
        if ((w_cq_p & w_cq_d) != '0) w_cand = w_cq_p & w_cq_d & cd_valids_i;
`endif
        w_pick = '0;
        for (int j = NumOup - 1; j >= 0; j--) begin
            if (w_cand[j]) w_pick = FW'(j);
        end
        w_pick_vld = |w_cand;
    end

    assign w_busy = (r_state == S_SELECT) || (r_state == S_STREAM);
    assign w_fwd  = (r_state == S_STREAM) ||
                    ((r_state == S_SELECT) && w_pick_vld);
    assign w_fsel = (r_state == S_STREAM) ? r_first : w_pick;

    assign w_last_hs  = cd_valids_i & cd_readies_o & lasts(cd_chans_i);
    assign w_done_nxt = r_done | w_last_hs;
    assign w_all_done = w_busy && (w_done_nxt == w_cq_d);

    function automatic logic [NumOup-1:0] lasts(
        input logic [NumOup*CdW-1:0] c
    );
        logic [NumOup-1:0] l;
        for (int j = 0; j < NumOup; j++) l[j] = c[j*CdW];
        return l;
    endfunction

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_first <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_SELECT && w_pick_vld) r_first <= w_pick;
            if (w_cq_pop)    r_done <= '0;
            else if (w_busy) r_done <= w_done_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_cq_empty && w_cq_d != '0) w_state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (w_all_done)      w_state_nxt = S_IDLE;
                else if (w_pick_vld) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_all_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs. Finished masters get ready 0 so the next transaction's
    // burst is held off rather than swallowed.
    always_comb begin
        cd_readies_o = '0;
        cd_valid_o   = 1'b0;
        cd_chan_o    = '0;
        w_cq_pop     = 1'b0;
        if (w_busy) begin
            cd_readies_o = w_cq_d & ~r_done;
            if (w_fwd && !r_done[w_fsel]) begin
                cd_readies_o[w_fsel] = cd_ready_i;
                cd_valid_o           = cd_valids_i[w_fsel];
                cd_chan_o            = cd_chans_i[w_fsel*CdW +: CdW];
            end
            w_cq_pop = w_all_done;
        end else if (!w_cq_empty && w_cq_d == '0) begin
            w_cq_pop = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_sq_push && !w_cq_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_sq_push && w_cq_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign trans_cnt_o = r_cnt;
endmodule

// File: tb/tb_ace_ccu_snoop_resp_pipe.sv
// tb_ace_ccu_snoop_resp_pipe: directed bench for the snoop response pipe.
// Build with or without ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN.
module tb_ace_ccu_snoop_resp_pipe;
    logic        clk;
    logic        rst;
    logic [1:0]  oup_sel_i;
    logic        oup_sel_valid_i;
    logic        oup_sel_ready_o;
    logic [1:0]  cr_valids_i;
    logic [1:0]  cr_readies_o;
    logic [9:0]  cr_chans_i;
    logic [1:0]  cd_valids_i;
    logic [1:0]  cd_readies_o;
    logic [17:0] cd_chans_i;
    logic        cr_valid_o;
    logic        cr_ready_i;
    logic [4:0]  cr_chan_o;
    logic        cd_valid_o;
    logic        cd_ready_i;
    logic [8:0]  cd_chan_o;
    logic [2:0]  trans_cnt_o;

    int tests = 0;
    int fails = 0;

    ace_ccu_snoop_resp_pipe #(
        .NumOup   (2),
        .MaxTrans (4),
        .CdW      (9)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .oup_sel_i       (oup_sel_i),
        .oup_sel_valid_i (oup_sel_valid_i),
        .oup_sel_ready_o (oup_sel_ready_o),
        .cr_valids_i     (cr_valids_i),
        .cr_readies_o    (cr_readies_o),
        .cr_chans_i      (cr_chans_i),
        .cd_valids_i     (cd_valids_i),
        .cd_readies_o    (cd_readies_o),
        .cd_chans_i      (cd_chans_i),
        .cr_valid_o      (cr_valid_o),
        .cr_ready_i      (cr_ready_i),
        .cr_chan_o       (cr_chan_o),
        .cd_valid_o      (cd_valid_o),
        .cd_ready_i      (cd_ready_i),
        .cd_chan_o       (cd_chan_o),
        .trans_cnt_o     (trans_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_rdy;
        logic [7:0] d1;
        logic [7:0] d0;

        rst = 1'b1;
        oup_sel_i = '0;
        oup_sel_valid_i = 1'b0;
        cr_valids_i = '0;
        cr_chans_i = '0;
        cd_valids_i = '0;
        cd_chans_i = '0;
        cr_ready_i = 1'b0;
        cd_ready_i = 1'b0;

        // Reset state
        #2;
        chk("rst_sel_ready", 32'(oup_sel_ready_o), 32'(1));
        chk("rst_cr_valid", 32'(cr_valid_o), 32'(0));
        chk("rst_cd_valid", 32'(cd_valid_o), 32'(0));
        chk("rst_cr_readies", 32'(cr_readies_o), 32'(0));
        chk("rst_cd_readies", 32'(cd_readies_o), 32'(0));
        chk("rst_cr_chan", 32'(cr_chan_o), 32'(0));
        chk("rst_cd_chan", 32'(cd_chan_o), 32'(0));
        chk("rst_cnt", 32'(trans_cnt_o), 32'(0));
        tick();
        rst = 1'b0;

        // Single master, no data
        oup_sel_i = 2'b01;
        oup_sel_valid_i = 1'b1;
        #1 chk("t1_sel_ready", 32'(oup_sel_ready_o), 32'(1));
        tick();
        oup_sel_valid_i = 1'b0;
        oup_sel_i = '0;
        #1 chk("t1_cnt1", 32'(trans_cnt_o), 32'(1));
        chk("t1_cr_wait", 32'(cr_valid_o), 32'(0));
        cr_valids_i = 2'b01;
        cr_chans_i = 10'b00000_01000;
        cr_ready_i = 1'b1;
        #1 chk("t1_cr_valid", 32'(cr_valid_o), 32'(1));
        chk("t1_cr_chan", 32'(cr_chan_o), 32'h08);
        chk("t1_cr_readies", 32'(cr_readies_o), 32'(1));
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        #1 chk("t1_cnt_hold", 32'(trans_cnt_o), 32'(1));
        chk("t1_no_cd", 32'(cd_readies_o), 32'(0));
        chk("t1_sq_empty", 32'(cr_valid_o), 32'(0));
        tick();
        chk("t1_cnt0", 32'(trans_cnt_o), 32'(0));

        // Merge and first-responder forwarding
        oup_sel_i = 2'b11;
        oup_sel_valid_i = 1'b1;
        tick();
        oup_sel_valid_i = 1'b0;
        cr_valids_i = 2'b10;
        cr_chans_i = {5'b00001, 5'b10001};
        #1 chk("t2_cr_partial", 32'(cr_valid_o), 32'(0));
        chk("t2_cr_rdy_partial", 32'(cr_readies_o), 32'(0));
        cr_valids_i = 2'b11;
        #1 chk("t2_cr_valid", 32'(cr_valid_o), 32'(1));
        chk("t2_cr_chan", 32'(cr_chan_o), 32'h11);
        chk("t2_cr_readies", 32'(cr_readies_o), 32'(3));
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        cd_ready_i = 1'b1;
        cd_valids_i = 2'b10;
        cd_chans_i = {9'h140, 9'h000};
        #1 chk("t2_idle_rdy", 32'(cd_readies_o), 32'(0));
        chk("t2_idle_vld", 32'(cd_valid_o), 32'(0));
        tick();
        for (int c = 0; c < 6; c++) begin
            d1 = 8'(8'hA0 + c);
            d0 = 8'(8'hAE + c);
            cd_chans_i = {d1, (c == 3), d0, (c == 5)};
            cd_valids_i = {(c <= 3), (c >= 2)};
            exp_rdy = {(c <= 3), 1'b1};
            #1 chk("t2_cd_valid", 32'(cd_valid_o), 32'(c <= 3));
            chk("t2_cd_readies", 32'(cd_readies_o), 32'(exp_rdy));
            chk("t2_cnt", 32'(trans_cnt_o), 32'(1));
            if (c <= 3) chk("t2_cd_chan", 32'(cd_chan_o), 32'({d1, (c == 3)}));
            tick();
        end
        cd_valids_i = '0;
        cd_chans_i = '0;
        #1 chk("t2_cnt0", 32'(trans_cnt_o), 32'(0));
        chk("t2_rdy_after", 32'(cd_readies_o), 32'(0));

        // Queue full
        cr_ready_i = 1'b0;
        oup_sel_i = 2'b01;
        oup_sel_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_sel_ready", 32'(oup_sel_ready_o), 32'(1));
            tick();
        end
        oup_sel_valid_i = 1'b0;
        #1 chk("t3_full", 32'(oup_sel_ready_o), 32'(0));
        chk("t3_cnt4", 32'(trans_cnt_o), 32'(4));
        cr_valids_i = 2'b01;
        cr_ready_i = 1'b1;
        #1 chk("t3_cr_valid", 32'(cr_valid_o), 32'(1));
        tick();
        cr_ready_i = 1'b0;
        #1 chk("t3_reopen", 32'(oup_sel_ready_o), 32'(1));
        chk("t3_cnt_still4", 32'(trans_cnt_o), 32'(4));
        cr_ready_i = 1'b1;
        repeat (3) tick();
        cr_ready_i = 1'b0;
        cr_valids_i = '0;
        repeat (2) tick();
        chk("t3_drained", 32'(trans_cnt_o), 32'(0));

        // Early CD held off
        oup_sel_i = 2'b01;
        oup_sel_valid_i = 1'b1;
        tick();
        oup_sel_i = 2'b10;
        tick();
        oup_sel_valid_i = 1'b0;
        cr_valids_i = 2'b11;
        cr_chans_i = {5'b00001, 5'b00001};
        cr_ready_i = 1'b1;
        #1 chk("t4_cr_rdy1", 32'(cr_readies_o), 32'(1));
        tick();
        chk("t4_cr_rdy2", 32'(cr_readies_o), 32'(2));
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        cd_valids_i = 2'b11;
        cd_chans_i = {9'h1A1, 9'h180};
        #1 chk("t4_fwd0", 32'(cd_valid_o), 32'(1));
        chk("t4_chan0", 32'(cd_chan_o), 32'h180);
        chk("t4_hold1", 32'(cd_readies_o), 32'(1));
        tick();
        cd_chans_i = {9'h1A1, 9'h183};
        #1 chk("t4_hold1b", 32'(cd_readies_o), 32'(1));
        chk("t4_chan1", 32'(cd_chan_o), 32'h183);
        tick();
        cd_valids_i = 2'b10;
        #1 chk("t4_idle_rdy", 32'(cd_readies_o), 32'(0));
        chk("t4_idle_vld", 32'(cd_valid_o), 32'(0));
        tick();
        chk("t4_fwd1", 32'(cd_valid_o), 32'(1));
        chk("t4_chan2", 32'(cd_chan_o), 32'h1A1);
        chk("t4_rdy2", 32'(cd_readies_o), 32'(2));
        tick();
        cd_valids_i = '0;
        cd_chans_i = '0;
        #1 chk("t4_cnt0", 32'(trans_cnt_o), 32'(0));

        // Dirty priority
        oup_sel_i = 2'b11;
        oup_sel_valid_i = 1'b1;
        tick();
        oup_sel_valid_i = 1'b0;
        cr_valids_i = 2'b11;
        cr_chans_i = {5'b00101, 5'b00001};
        #1 chk("t5_cr_chan", 32'(cr_chan_o), 32'h05);
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        tick();
        cd_valids_i = 2'b01;
        cd_chans_i = {9'h000, 9'h1C1};
        #1 chk("t5_rdy_a", 32'(cd_readies_o), 32'(3));
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
        chk("t5_clean_drained", 32'(cd_valid_o), 32'(0));
`else
        chk("t5_clean_fwd", 32'(cd_valid_o), 32'(1));
        chk("t5_clean_chan", 32'(cd_chan_o), 32'h1C1);
`endif
        tick();
        cd_valids_i = 2'b10;
        cd_chans_i = {9'h1E3, 9'h000};
        #1 chk("t5_rdy_b", 32'(cd_readies_o), 32'(2));
`ifdef ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN
        chk("t5_dirty_fwd", 32'(cd_valid_o), 32'(1));
        chk("t5_dirty_chan", 32'(cd_chan_o), 32'h1E3);
`else
        chk("t5_dirty_drained", 32'(cd_valid_o), 32'(0));
`endif
        tick();
        cd_valids_i = '0;
        cd_chans_i = '0;
        #1 chk("t5_cnt0", 32'(trans_cnt_o), 32'(0));

        // Reset mid-burst
        oup_sel_i = 2'b01;
        oup_sel_valid_i = 1'b1;
        tick();
        oup_sel_valid_i = 1'b0;
        cr_valids_i = 2'b01;
        cr_chans_i = 10'b00000_00001;
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        tick();
        cd_valids_i = 2'b01;
        cd_chans_i = {9'h000, 9'h0AA};
        #1 chk("t6_fwd", 32'(cd_valid_o), 32'(1));
        tick();
        cd_chans_i = {9'h000, 9'h0AC};
        #1 rst = 1'b1;
        #1 chk("t6_rst_cd_valid", 32'(cd_valid_o), 32'(0));
        chk("t6_rst_cd_rdy", 32'(cd_readies_o), 32'(0));
        chk("t6_rst_cnt", 32'(trans_cnt_o), 32'(0));
        chk("t6_rst_sel_rdy", 32'(oup_sel_ready_o), 32'(1));
        chk("t6_rst_cd_chan", 32'(cd_chan_o), 32'(0));
        rst = 1'b0;
        cd_valids_i = '0;
        cd_chans_i = '0;
        tick();
        oup_sel_i = 2'b01;
        oup_sel_valid_i = 1'b1;
        tick();
        oup_sel_valid_i = 1'b0;
        cr_valids_i = 2'b01;
        cr_chans_i = 10'b00000_00001;
        #1 chk("t6_new_cr", 32'(cr_valid_o), 32'(1));
        tick();
        cr_valids_i = '0;
        cr_chans_i = '0;
        tick();
        cd_valids_i = 2'b01;
        cd_chans_i = {9'h000, 9'h0EF};
        #1 chk("t6_new_fwd", 32'(cd_valid_o), 32'(1));
        chk("t6_new_chan", 32'(cd_chan_o), 32'h0EF);
        tick();
        cd_valids_i = '0;
        cd_chans_i = '0;
        #1 chk("t6_new_cnt0", 32'(trans_cnt_o), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ace_ccu_snoop_resp_pipe.md
# ace_ccu_snoop_resp_pipe

Multi-outstanding successor to the single-transaction snoop response combiner in the CCU. It queues up to `MaxTrans` snoop selection masks and merges the CR responses of each transaction in order. It then forwards exactly one responder's CD burst per transaction to the CCU and drains the CD bursts of all other data-carrying responders. It sits between the per-master snoop response ports and the CCU's CR/CD consumers.

## Interface
- `NumOup`, 2: number of snooped masters (≥1).
- `MaxTrans`, 4: outstanding snoop transactions (≥1); depth of both internal queues.
- `cr_chan_t`, logic: CR struct with fields WasUnique, IsShared, PassDirty, Error, DataTransfer.
- `cd_chan_t`, logic: CD struct containing `last`.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `oup_sel_i` in NumOup: masters snooped by the new transaction.
- `oup_sel_valid_i` in 1 / `oup_sel_ready_o` out 1: selection handshake.
- `cr_valids_i` in NumOup / `cr_readies_o` out NumOup / `cr_chans_i` in NumOup×cr_chan_t: per-master CR.
- `cd_valids_i` in NumOup / `cd_readies_o` out NumOup / `cd_chans_i` in NumOup×cd_chan_t: per-master CD.
- `cr_valid_o` out 1 / `cr_ready_i` in 1 / `cr_chan_o` out cr_chan_t: combined CR.
- `cd_valid_o` out 1 / `cd_ready_i` in 1 / `cd_chan_o` out cd_chan_t: forwarded CD.
- `trans_cnt_o` out $clog2(MaxTrans+1): transactions accepted but not yet retired from the CD queue.

## Operation
- **Sel queue (SQ).** Non-fall-through FIFO of masks, depth MaxTrans.
  - Push on the oup_sel handshake; `oup_sel_ready_o` = !SQ full.
  - An all-zero mask is legal.
- **CR stage.** Operates on the SQ head mask M.
  - `cr_valid_o` = SQ non-empty & CQ not full & all `cr_valids_i[j]` high for j∈M.
  - `cr_chan_o` = bitwise OR of each field over j∈M. It is '0 when M=0; in that case `cr_valid_o` needs only SQ non-empty & CQ not full.
  - `cr_readies_o[j]` = (j∈M) & `cr_valid_o` & `cr_ready_i`; it is 0 for masters not in M.
  - On the CR handshake: pop SQ; push into CQ the entry {D = M & DataTransfer bits, P = M & PassDirty bits}.
- **CD queue (CQ).** FIFO of {D,P}, depth MaxTrans. Entries are retired in order.
- **CD FSM.** Operates on the CQ head.
  - **IDLE.**
    - If CQ is empty, stay in IDLE.
    - If the head has D=0, pop CQ this cycle and stay in IDLE.
    - Otherwise go to SELECT.
  - **SELECT.** The first responder F is the lowest j∈D with `cd_valids_i[j]` high, chosen in the first cycle any such valid is seen. Latch F and go to STREAM; forwarding starts that same cycle.
  - **STREAM.**
    - Master F: `cd_valid_o` = `cd_valids_i[F]`, `cd_chan_o` = `cd_chans_i[F]`, `cd_readies_o[F]` = `cd_ready_i`.
    - Masters j∈D, j≠F: `cd_readies_o[j]` = 1 and beats are discarded. They are also drained while in SELECT.
    - Track a per-master done mask, set by the handshake of each master's beat with `last`=1.
    - When done == D: pop CQ and go to IDLE.
  - `cd_readies_o[j]` = 0 for j∉D (including when CQ is empty). Early CD for a later transaction is held off, not dropped.
- **Counter.** `trans_cnt_o` increments on the SQ push and decrements on the CQ pop. Both in one cycle leaves it unchanged.

## Timing
- **Reset values.** All outputs deassert: `oup_sel_ready_o` = 1, all valids and readies 0, chans '0, `trans_cnt_o` = 0. Queues empty, FSM in IDLE, done mask 0, F = 0.
- **Latency.**
  - A mask pushed in cycle t is at the SQ head in t+1.
  - CR out is combinational from the CR inputs when the head is present.
  - The CQ entry is visible in the cycle after the CR handshake.
  - CD forwarding is combinational (0-cycle) once F is latched or chosen.
- **Simultaneous events.**
  - SQ push/pop and CQ push/pop in the same cycle are allowed at any fill level, except pushes when full.
  - A single-beat transfer and the pop of its CQ entry may occur in the same cycle.
- **Valid stability.** Valid outputs never retract without a handshake, provided inputs obey AXI valid stability.
- **Reset mid-operation.** Asserting `rst_i` discards all queued transactions and partial bursts immediately (asynchronous).

## Configuration
- `ACE_CCU_SNOOP_RESP_DIRTY_PRIO_EN`
  - **Defined.** When the head P≠0, SELECT only considers j∈P. F is the lowest j∈P with valid; non-dirty responders are drained meanwhile.
  - **Undefined.** P is not stored and F is chosen as first-arrival among D, as above.

## Test plan
- **Single master, no data.** Mask 0b01, CR {IsShared=1, DataTransfer=0} → `cr_chan_o`.IsShared=1. No CD accepted. `trans_cnt_o` 1→0 on the cycle after the CR handshake.
- **Merge and first-responder forwarding.** Mask 0b11, both DataTransfer=1, master1 CD valid 2 cycles before master0 (4 beats each) → master1's 4 beats forwarded; master0's 4 drained with `cd_valid_o`=0; CQ popped after both `last`s.
- **Queue full.** 4 masks pushed, `cr_ready_i`=0 → `oup_sel_ready_o`=0 after the 4th push; `trans_cnt_o`=4. A pop re-opens ready the next cycle.
- **Early CD held off.** CD for transaction 2 held with ready 0 while transaction 1 streams. Accepted only after transaction 1's CQ pop.
- **Dirty priority.** With the macro: mask 0b11, master0 clean data arrives first, master1 PassDirty=1 → master1 forwarded, master0 drained. Without the macro: master0 forwarded.
- **Reset mid-burst.** Assert `rst_i` mid-burst → all outputs at reset values within the same cycle; a new transaction after release completes normally.
